// File: rtl/button_input_pkg.sv
// Shared constants for the button/switch input port: register offsets,
// the widest supported input bank and a byte-select expansion helper.
package button_input_pkg;

  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_RISE   = 2'd1;
  localparam logic [1:0] REG_FALL   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam int MAX_INPUTS = 16;

  // Expand the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byteMask(input logic [3:0] sel);
    byteMask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/input_filter.sv
// One raw board input: two-flop synchronizer followed by a debounce
// counter. change_o pulses on the cycle whose clock edge updates stable_o,
// so edge flags can be set on exactly that edge.
module input_filter #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic slow_clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic change_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous pin into the slow_clk domain.
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for a full run of samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    change_o = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      change_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/button_input_wb.sv
// Wishbone classic slave exposing debounced board inputs, sticky
// rise/fall flags (write-one-to-clear) and a registered level interrupt.
module button_input_wb
  import button_input_pkg::*;
#(
  parameter int N_INPUTS        = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                slow_clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  input  logic                wb_cyc_in,
  input  logic                wb_stb_in,
  input  logic                wb_we_in,
  input  logic [1:0]          wb_adr_in,
  input  logic [31:0]         wb_dat_in,
  input  logic [3:0]          wb_sel_in,
  output logic [31:0]         wb_dat_out,
  output logic                wb_ack_out,
  output logic                irq_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [N_INPUTS-1:0] stable;
  logic [N_INPUTS-1:0] change;

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [31:0]         dat_q;
  logic [N_INPUTS-1:0] rise_q;
  logic [N_INPUTS-1:0] rise_d;
  logic [N_INPUTS-1:0] fall_q;
  logic [N_INPUTS-1:0] fall_d;
  logic [N_INPUTS-1:0] enR_q;
  logic [N_INPUTS-1:0] enR_d;
  logic [N_INPUTS-1:0] enF_q;
  logic [N_INPUTS-1:0] enF_d;
  logic                irq_q;
  logic                irq_d;

  logic                req;
  logic                wrReq;
  logic [31:0]         selMask;
  logic [31:0]         clrMask;
  logic [31:0]         readWord;
  logic                unused_ok;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : gen_filter
      input_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .slow_clk(slow_clk),
        .reset   (reset),
        .raw_i   (raw_in[gi]),
        .stable_o(stable[gi]),
        .change_o(change[gi])
      );
    end
  endgenerate

  // A request is accepted only from IDLE, which forces a gap cycle after each ack.
  assign req     = wb_cyc_in & wb_stb_in & (state_q == ST_IDLE);
  assign wrReq   = req & wb_we_in;
  assign selMask = byteMask(wb_sel_in);
  assign clrMask = wb_dat_in & selMask;

  // Two-state bus handshake: IDLE -> ACK for one cycle -> IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = (wb_cyc_in & wb_stb_in) ? ST_ACK : ST_IDLE;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag and enable next-state: new edges set flags even when software clears them in the same cycle.
  always_comb begin
    rise_d = rise_q & ~((wrReq && wb_adr_in == REG_RISE) ? clrMask[N_INPUTS-1:0] : '0);
    fall_d = fall_q & ~((wrReq && wb_adr_in == REG_FALL) ? clrMask[N_INPUTS-1:0] : '0);
    rise_d = rise_d | (change & ~stable);
    fall_d = fall_d | (change & stable);
    enR_d  = enR_q;
    enF_d  = enF_q;
    if (wrReq && wb_adr_in == REG_IRQ_EN) begin
      enR_d = (enR_q & ~selMask[N_INPUTS-1:0])
            | (wb_dat_in[N_INPUTS-1:0] & selMask[N_INPUTS-1:0]);
      enF_d = (enF_q & ~selMask[MAX_INPUTS +: N_INPUTS])
            | (wb_dat_in[MAX_INPUTS +: N_INPUTS] & selMask[MAX_INPUTS +: N_INPUTS]);
    end
  end

  // Read mux; bits beyond the implemented inputs stay zero.
  always_comb begin
    readWord = '0;
    case (wb_adr_in)
      REG_STATE:  readWord[N_INPUTS-1:0] = stable;
      REG_RISE:   readWord[N_INPUTS-1:0] = rise_q;
      REG_FALL:   readWord[N_INPUTS-1:0] = fall_q;
      REG_IRQ_EN: begin
        readWord[N_INPUTS-1:0]            = enR_q;
        readWord[MAX_INPUTS +: N_INPUTS]  = enF_q;
      end
      default:    readWord = '0;
    endcase
  end

  // Interrupt is any enabled sticky flag, computed from the registered flags.
  always_comb begin
    irq_d = |((rise_q & enR_q) | (fall_q & enF_q));
  end

  // All architectural state; reset wins over any pending bus request.
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dat_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      enR_q   <= '0;
      enF_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req) begin
        dat_q <= readWord;
      end
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      enR_q   <= enR_d;
      enF_q   <= enF_d;
      irq_q   <= irq_d;
    end
  end

  assign wb_ack_out = (state_q == ST_ACK);
  assign wb_dat_out = dat_q;
  assign irq_out    = irq_q;

  assign unused_ok = &{1'b0, wb_dat_in, selMask, clrMask};

endmodule
